alu_seq: RTL and testbench
==========================

# alu_seq

Parametrised, handshaked ALU. It extends the 4-bit combinational add/sub unit with a parametrised width, the full logic and compare op set, and a configurable overflow policy. It adds an iterative signed multiplier, which makes the block sequential. It sits between the decode stage and writeback in the npc datapath and is fed through a valid/ready handshake on both sides.

## Interface
- `WIDTH`, 32: operand and result width in bits, must be ≥ 4.
- `SAT_MODE`, 0: overflow policy for ADD/SUB/MUL.
  - 0: force the result to 0 (legacy behaviour).
  - 1: saturate the result.
  - 2: wrap the result.
- `clk` input 1: the block's only clock. All state updates on the rising edge.
- `rst_n` input 1: reset, synchronous and active-low, sampled on the rising edge of `clk`.
- `in_valid` input 1: an operation is offered.
- `in_ready` output 1: the block can accept an operation.
- `op` input 4: operation code.
- `a`, `b` input WIDTH each: signed two's-complement operands.
- `out_valid` output 1: the result is valid.
- `out_ready` input 1: the consumer takes the result.
- `result` output WIDTH: result value.
- `overflow` output 1: signed overflow occurred (ADD/SUB/MUL only).
- `zero` output 1: `result` is all zeros.

## Operation
- Op codes:
  - 0 ADD, 1 SUB (a−b), 2 NOT (~a), 3 AND, 4 OR, 5 XOR.
  - 6 SLT: result 1 if a<b signed, else 0.
  - 7 EQ: result 1 if a==b, else 0.
  - 8 MUL: low WIDTH bits of the signed product a×b.
  - 9–15 illegal: result 0, overflow 0.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: `in_ready`=1. On `in_valid`, latch op/a/b.
    - op 8 goes to BUSY.
    - Every other op computes its result on the same edge and goes to DONE.
  - BUSY: one multiplier iteration per cycle, WIDTH iterations, then DONE.
    - `in_ready`=0.
    - `in_valid` is ignored.
  - DONE: `out_valid`=1; `result`, `overflow` and `zero` are held stable. On `out_ready`=1 go to IDLE.
- Operands are captured at acceptance. Later changes on `a`, `b` or `op` have no effect.
- ADD/SUB overflow: computed at WIDTH+1 bits with sign extension. Overflow is set when the top two bits of the sum differ.
- MUL: shift-and-add on operand magnitudes, 2·WIDTH-bit accumulator, final sign correction. Overflow is set when the full product differs from the sign-extension of its low WIDTH bits.
- On overflow, `overflow`=1 in every mode, and `result` is set as follows:
  - Mode 0: 0.
  - Mode 1: signed max (0111…) if the true result is positive, signed min (1000…) if negative. For MUL the true sign is sign(a)^sign(b).
  - Mode 2: truncated value.
- `zero` is computed from the final `result`, after the overflow policy is applied. A forced-0 result therefore gives `zero`=1.
- Illegal op: result 0, `zero`=1, `overflow`=0, 1-cycle latency. No error flag.

## Timing
- Reset (`rst_n`=0 at an edge): state goes to IDLE. `out_valid`, `result`, `overflow` and `zero` all become 0.
- Reset mid-operation: any in-flight operation is discarded and no result is produced.
- `in_ready` is 0 while `rst_n`=0 and rises in the first cycle after reset is released.
- Latency, counted from the acceptance edge to `out_valid` high:
  - Non-MUL ops: 1 cycle.
  - MUL: WIDTH+1 cycles.
- Maximum throughput is one operation per 2 cycles. `in_ready` is 0 in BUSY and DONE, so acceptance is never possible on the same edge as a DONE→IDLE transfer.
- `out_valid` stays high until the transfer edge. Output values must not change while `out_valid`=1 and `out_ready`=0.
- If `out_ready` is already high on the first DONE cycle, the result transfers on that edge. `out_valid` is then high for exactly one cycle.

## Test plan
All scenarios use WIDTH=8.
- Legacy overflow: SAT_MODE=0, ADD 0x7F+0x01 → result 0x00, overflow 1, zero 1, `out_valid` 1 cycle after accept.
- Saturation: SAT_MODE=1.
  - ADD 0x7F+0x01 → 0x7F, overflow 1.
  - SUB 0x80−0x01 → 0x80, overflow 1.
  - SAT_MODE=2 SUB 0x80−0x01 → 0x7F, overflow 1.
- Logic/compare:
  - AND 0xF0,0x3C → 0x30.
  - SLT 0xFF,0x01 → 0x01.
  - EQ 0x5A,0x5A → 0x01.
  - op 12 → 0x00, zero 1.
- MUL:
  - 0xFD×0x05 → 0xF1, overflow 0, `out_valid` exactly 9 cycles after accept.
  - SAT_MODE=0 0x10×0x10 → 0x00, overflow 1.
  - SAT_MODE=1 0xF0×0x10 → 0x80, overflow 1.
- Backpressure: hold `out_ready`=0 for 5 cycles after `out_valid` rises → outputs stable, `in_ready` 0. Then `out_ready`=1 → IDLE next cycle and a new op is accepted.
- Reset mid-MUL: assert `rst_n`=0 on the 4th BUSY cycle → all outputs 0 next cycle, no `out_valid`. After release, ADD 0x02+0x03 → 0x05.

Source files
------------

// File: rtl/alu_seq.sv
// Handshaked ALU: add/sub/logic/compare in one cycle, iterative signed multiply.
// Latency: 1 cycle from acceptance for non-MUL ops, WIDTH+1 cycles for MUL.
// Backpressure: one op in flight; in_ready low until the result is taken via out_ready.
module alu_seq #(
    parameter int WIDTH    = 32,
    parameter int SAT_MODE = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             overflow,
    output logic             zero
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam int               CW    = $clog2(WIDTH);
    localparam logic [CW-1:0]    LAST  = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] S_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] S_MIN = {1'b1, {(WIDTH-1){1'b0}}};

    logic [1:0]         state_q, state_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               ovf_q, ovf_d;
    logic               zero_q, zero_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic               neg_q, neg_d;
    logic [CW-1:0]      cnt_q, cnt_d;

    logic [WIDTH:0]     sum_add, sum_sub;
    logic [WIDTH-1:0]   alu_res;
    logic               alu_ovf;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [2*WIDTH-1:0] acc_nxt, prod;
    logic               mul_ovf;
    logic [WIDTH-1:0]   mul_res;

    // Overflow policy shared by ADD/SUB/MUL; neg is the sign of the true result.
    function automatic logic [WIDTH-1:0] apply_policy(input logic [WIDTH-1:0] val,
                                                      input logic ovf, input logic neg);
        logic [WIDTH-1:0] r;
        r = val;
        if (ovf) begin
            case (SAT_MODE)
                1:       r = neg ? S_MIN : S_MAX;
                2:       r = val;
                default: r = '0;
            endcase
        end
        return r;
    endfunction

    assign sum_add = {a[WIDTH-1], a} + {b[WIDTH-1], b};
    assign sum_sub = {a[WIDTH-1], a} - {b[WIDTH-1], b};
    assign mag_a   = a[WIDTH-1] ? ('0 - a) : a;
    assign mag_b   = b[WIDTH-1] ? ('0 - b) : b;

    // Single-cycle ops evaluated straight from the offered operands.
    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        case (op)
            4'd0: begin
                alu_ovf = sum_add[WIDTH] ^ sum_add[WIDTH-1];
                alu_res = apply_policy(sum_add[WIDTH-1:0], alu_ovf, sum_add[WIDTH]);
            end
            4'd1: begin
                alu_ovf = sum_sub[WIDTH] ^ sum_sub[WIDTH-1];
                alu_res = apply_policy(sum_sub[WIDTH-1:0], alu_ovf, sum_sub[WIDTH]);
            end
            4'd2:    alu_res = ~a;
            4'd3:    alu_res = a & b;
            4'd4:    alu_res = a | b;
            4'd5:    alu_res = a ^ b;
            4'd6:    alu_res = WIDTH'($signed(a) < $signed(b));
            4'd7:    alu_res = WIDTH'(a == b);
            default: alu_res = '0;
        endcase
    end

    // Multiplier step and final sign correction; the last step feeds the result directly.
    always_comb begin
        acc_nxt = acc_q + (mplier_q[0] ? mcand_q : '0);
        prod    = neg_q ? ('0 - acc_nxt) : acc_nxt;
        mul_ovf = prod != {{WIDTH{prod[WIDTH-1]}}, prod[WIDTH-1:0]};
        mul_res = apply_policy(prod[WIDTH-1:0], mul_ovf, neg_q);
    end

    // Next-state logic for the IDLE/BUSY/DONE controller and datapath registers.
    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        neg_d    = neg_q;
        cnt_d    = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    if (op == 4'd8) begin
                        mcand_d  = {{WIDTH{1'b0}}, mag_a};
                        mplier_d = mag_b;
                        acc_d    = '0;
                        neg_d    = a[WIDTH-1] ^ b[WIDTH-1];
                        cnt_d    = '0;
                        state_d  = S_BUSY;
                    end else begin
                        result_d = alu_res;
                        ovf_d    = alu_ovf;
                        zero_d   = (alu_res == '0);
                        state_d  = S_DONE;
                    end
                end
            end
            S_BUSY: begin
                acc_d    = acc_nxt;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    result_d = mul_res;
                    ovf_d    = mul_ovf;
                    zero_d   = (mul_res == '0);
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers with synchronous active-low reset; reset discards any in-flight op.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            result_q <= '0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            neg_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            neg_q    <= neg_d;
            cnt_q    <= cnt_d;
        end
    end

    // in_ready is gated by rst_n so it stays low for the whole reset window.
    assign in_ready  = rst_n && (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign result    = result_q;
    assign overflow  = ovf_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq at WIDTH=8: three instances (SAT_MODE 0/1/2) share one stimulus stream.
// Table of directed vectors plus hand sequences for backpressure and reset corner cases.
// Inputs driven and outputs sampled 1 time unit after the rising edge.
module tb_alu_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [3:0] op;
    logic [7:0] a, b;
    logic       out_ready;
    logic       in_ready  [3];
    logic       out_valid [3];
    logic [7:0] res       [3];
    logic       ovf       [3];
    logic       zro       [3];

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(8), .SAT_MODE(0)) u0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[0]),
        .op(op), .a(a), .b(b), .out_valid(out_valid[0]), .out_ready(out_ready),
        .result(res[0]), .overflow(ovf[0]), .zero(zro[0]));
    alu_seq #(.WIDTH(8), .SAT_MODE(1)) u1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[1]),
        .op(op), .a(a), .b(b), .out_valid(out_valid[1]), .out_ready(out_ready),
        .result(res[1]), .overflow(ovf[1]), .zero(zro[1]));
    alu_seq #(.WIDTH(8), .SAT_MODE(2)) u2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready[2]),
        .op(op), .a(a), .b(b), .out_valid(out_valid[2]), .out_ready(out_ready),
        .result(res[2]), .overflow(ovf[2]), .zero(zro[2]));

    typedef struct {
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] r0;
        logic [7:0] r1;
        logic [7:0] r2;
        logic       ovf;
        int         lat;
    } vec_t;

    vec_t vecs [20];

    function automatic vec_t mk(input logic [3:0] o, input logic [7:0] va, input logic [7:0] vb,
                                input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2,
                                input logic eo, input int l);
        vec_t v;
        v.op = o; v.a = va; v.b = vb; v.r0 = e0; v.r1 = e1; v.r2 = e2; v.ovf = eo; v.lat = l;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Bounded wait for in_ready on all instances.
    task automatic wait_ready(input string name);
        int n;
        n = 0;
        while (!(in_ready[0] && in_ready[1] && in_ready[2]) && n < 50) begin
            tick();
            n++;
        end
        chk({name, "_in_ready_wait"}, {31'd0, in_ready[0] & in_ready[1] & in_ready[2]}, 32'd1);
    endtask

    // Offer one op, scramble the operand inputs after acceptance, check latency and outputs.
    task automatic run_op(input string name, input vec_t v);
        int         n;
        logic [7:0] exp_r [3];
        exp_r[0] = v.r0; exp_r[1] = v.r1; exp_r[2] = v.r2;
        wait_ready(name);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        op = v.op; a = v.a; b = v.b;
        tick();
        in_valid = 1'b0;
        op = 4'd3; a = 8'hA5; b = 8'h5A;
        n = 1;
        while (!out_valid[0] && n < 40) begin
            tick();
            n++;
        end
        chk({name, "_latency"}, n, v.lat);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("%s_m%0d_out_valid", name, i), {31'd0, out_valid[i]}, 32'd1);
            chk($sformatf("%s_m%0d_result", name, i), {24'd0, res[i]}, {24'd0, exp_r[i]});
            chk($sformatf("%s_m%0d_overflow", name, i), {31'd0, ovf[i]}, {31'd0, v.ovf});
            chk($sformatf("%s_m%0d_zero", name, i), {31'd0, zro[i]}, {31'd0, exp_r[i] == 8'h00});
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({name, "_out_valid_drop"}, {31'd0, out_valid[0]}, 32'd0);
    endtask

    initial begin
        //          op     a      b      mode0  mode1  mode2  ovf  lat
        vecs[0]  = mk(4'd0, 8'h7F, 8'h01, 8'h00, 8'h7F, 8'h80, 1'b1, 1);
        vecs[1]  = mk(4'd1, 8'h80, 8'h01, 8'h00, 8'h80, 8'h7F, 1'b1, 1);
        vecs[2]  = mk(4'd3, 8'hF0, 8'h3C, 8'h30, 8'h30, 8'h30, 1'b0, 1);
        vecs[3]  = mk(4'd6, 8'hFF, 8'h01, 8'h01, 8'h01, 8'h01, 1'b0, 1);
        vecs[4]  = mk(4'd7, 8'h5A, 8'h5A, 8'h01, 8'h01, 8'h01, 1'b0, 1);
        vecs[5]  = mk(4'd12, 8'h12, 8'h34, 8'h00, 8'h00, 8'h00, 1'b0, 1);
        vecs[6]  = mk(4'd8, 8'hFD, 8'h05, 8'hF1, 8'hF1, 8'hF1, 1'b0, 9);
        vecs[7]  = mk(4'd8, 8'h10, 8'h10, 8'h00, 8'h7F, 8'h00, 1'b1, 9);
        vecs[8]  = mk(4'd8, 8'hF0, 8'h10, 8'h00, 8'h80, 8'h00, 1'b1, 9);
        vecs[9]  = mk(4'd0, 8'h05, 8'h03, 8'h08, 8'h08, 8'h08, 1'b0, 1);
        vecs[10] = mk(4'd1, 8'h03, 8'h05, 8'hFE, 8'hFE, 8'hFE, 1'b0, 1);
        vecs[11] = mk(4'd2, 8'h0F, 8'h00, 8'hF0, 8'hF0, 8'hF0, 1'b0, 1);
        vecs[12] = mk(4'd4, 8'hA0, 8'h05, 8'hA5, 8'hA5, 8'hA5, 1'b0, 1);
        vecs[13] = mk(4'd5, 8'hFF, 8'h0F, 8'hF0, 8'hF0, 8'hF0, 1'b0, 1);
        vecs[14] = mk(4'd6, 8'h01, 8'hFF, 8'h00, 8'h00, 8'h00, 1'b0, 1);
        vecs[15] = mk(4'd7, 8'h5A, 8'h5B, 8'h00, 8'h00, 8'h00, 1'b0, 1);
        vecs[16] = mk(4'd8, 8'h80, 8'hFF, 8'h00, 8'h7F, 8'h80, 1'b1, 9);
        vecs[17] = mk(4'd8, 8'h80, 8'h80, 8'h00, 8'h7F, 8'h00, 1'b1, 9);
        vecs[18] = mk(4'd0, 8'h80, 8'h80, 8'h00, 8'h80, 8'h00, 1'b1, 1);
        vecs[19] = mk(4'd8, 8'h07, 8'hFD, 8'hEB, 8'hEB, 8'hEB, 1'b0, 9);

        rst_n = 1'b0; in_valid = 1'b0; op = 4'd0; a = 8'h00; b = 8'h00; out_ready = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("reset_m%0d_in_ready", i), {31'd0, in_ready[i]}, 32'd0);
            chk($sformatf("reset_m%0d_out_valid", i), {31'd0, out_valid[i]}, 32'd0);
            chk($sformatf("reset_m%0d_result", i), {24'd0, res[i]}, 32'd0);
            chk($sformatf("reset_m%0d_flags", i), {30'd0, ovf[i], zro[i]}, 32'd0);
        end
        rst_n = 1'b1;
        #1;
        chk("release_in_ready", {31'd0, in_ready[0]}, 32'd1);

        for (int i = 0; i < 20; i++) run_op($sformatf("vec%0d", i), vecs[i]);

        // Backpressure: result held for 5 cycles, new offers ignored, then a fresh accept.
        wait_ready("bp");
        in_valid = 1'b1; op = 4'd0; a = 8'h05; b = 8'h03;
        tick();
        op = 4'd4; a = 8'h30; b = 8'h03;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("bp_hold%0d_out_valid", k), {31'd0, out_valid[0]}, 32'd1);
            chk($sformatf("bp_hold%0d_result", k), {24'd0, res[0]}, 32'h08);
            chk($sformatf("bp_hold%0d_in_ready", k), {31'd0, in_ready[0]}, 32'd0);
            tick();
        end
        out_ready = 1'b1;
        tick();
        chk("bp_release_out_valid", {31'd0, out_valid[0]}, 32'd0);
        chk("bp_release_in_ready", {31'd0, in_ready[0]}, 32'd1);
        tick();
        in_valid = 1'b0;
        chk("bp_new_op_out_valid", {31'd0, out_valid[0]}, 32'd1);
        chk("bp_new_op_result", {24'd0, res[0]}, 32'h33);
        // out_ready already high on the first DONE cycle: out_valid lasts one cycle.
        tick();
        chk("bp_one_cycle_valid", {31'd0, out_valid[0]}, 32'd0);
        out_ready = 1'b0;

        // Leave a non-zero result behind so the reset clearing is visible.
        run_op("pre_rst", vecs[9]);

        // Reset on the 4th BUSY cycle of a MUL.
        wait_ready("rst");
        in_valid = 1'b1; op = 4'd8; a = 8'hFD; b = 8'h05;
        tick();
        chk("busy_in_ready", {31'd0, in_ready[0]}, 32'd0);
        tick();
        tick();
        tick();
        chk("busy4_out_valid", {31'd0, out_valid[0]}, 32'd0);
        rst_n = 1'b0;
        in_valid = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("midrst_m%0d_out_valid", i), {31'd0, out_valid[i]}, 32'd0);
            chk($sformatf("midrst_m%0d_result", i), {24'd0, res[i]}, 32'd0);
            chk($sformatf("midrst_m%0d_flags", i), {30'd0, ovf[i], zro[i]}, 32'd0);
            chk($sformatf("midrst_m%0d_in_ready", i), {31'd0, in_ready[i]}, 32'd0);
        end
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick();
            chk($sformatf("postrst%0d_no_valid", k), {31'd0, out_valid[0]}, 32'd0);
        end
        run_op("post_rst_add", mk(4'd0, 8'h02, 8'h03, 8'h05, 8'h05, 8'h05, 1'b0, 1));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
